// File: rtl/elixirchip_es1_spu_pkg.sv
// rtl/elixirchip_es1_spu_pkg.sv - shared SPU consumer types and width helper
package elixirchip_es1_spu_pkg;

    typedef struct packed {
        logic valid;
        logic clear;
    } spu_tag_t;

    function automatic int spu_ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_result_fifo.sv
// rtl/elixirchip_es1_spu_result_fifo.sv - first-word-fall-through result FIFO
module elixirchip_es1_spu_result_fifo
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type data_t = logic [7:0]
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  data_t                         push_data,
    input  logic                          pop,
    output data_t                         pop_data,
    output logic [spu_ptr_bits(DEPTH):0]  count,
    output logic                          empty,
    output logic                          full
);

    localparam int PW = spu_ptr_bits(DEPTH);
    localparam int CW = PW + 1;

    data_t          r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Head is forced to zero while empty so stale entries never show after reset.
    assign pop_data = empty ? data_t'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_result_sink.sv
// rtl/elixirchip_es1_spu_result_sink.sv - SPU op result sink; optional counters via ELIXIRCHIP_ES1_SPU_RESULT_SINK_STATUS_EN
module elixirchip_es1_spu_result_sink
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int  LATENCY    = 3,
    parameter int  DATA_BITS  = 8,
    parameter type data_t     = logic [DATA_BITS-1:0],
    parameter int  FIFO_DEPTH = 4,
    parameter      DEVICE     = "RTL",
    parameter      SIMULATION = "false",
    parameter      DEBUG      = "false"
) (
    input  logic        reset,
    input  logic        clk,
    output logic        cke,
    input  logic        s_valid,
    input  logic        s_clear,
    input  data_t       op_data,
    output data_t       m_data,
    output logic        m_clear,
    output logic        m_valid,
    input  logic        m_ready
`ifdef ELIXIRCHIP_ES1_SPU_RESULT_SINK_STATUS_EN
    ,
    output logic [31:0] stat_results,
    output logic [31:0] stat_stalls
`endif
);

    localparam int CW = spu_ptr_bits(FIFO_DEPTH) + 1;

    typedef struct packed {
        data_t data;
        logic  clear;
    } entry_t;

    spu_tag_t        w_exit;
    entry_t          w_head;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_push;
    logic            w_pop;

    // String configuration is carried only for instance compatibility with the op.
    if (DEVICE == "" || SIMULATION == "" || DEBUG == "") begin : g_cfg_unset
    end

    if (LATENCY == 0) begin : g_lat0
        assign w_exit = {s_valid, s_clear};
    end else begin : g_tag_pipe
        spu_tag_t r_tag [LATENCY];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < LATENCY; k++) begin
                    r_tag[k] <= '0;
                end
            end else if (cke) begin
                r_tag[0] <= {s_valid, s_clear};
                for (int k = 1; k < LATENCY; k++) begin
                    r_tag[k] <= r_tag[k-1];
                end
            end
        end

        assign w_exit = r_tag[LATENCY-1];
    end

    // Stall depends only on registered state, never on m_ready.
    assign cke    = !(w_exit.valid && (w_fifo_count == CW'(FIFO_DEPTH)));
    assign w_push = w_exit.valid && !w_fifo_full;
    assign w_pop  = m_ready && !w_fifo_empty;

    elixirchip_es1_spu_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .data_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({op_data, w_exit.clear}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    assign m_data  = w_head.data;
    assign m_clear = w_head.clear;
    assign m_valid = !w_fifo_empty;

`ifdef ELIXIRCHIP_ES1_SPU_RESULT_SINK_STATUS_EN
    logic [31:0] r_stat_results;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_results <= '0;
            r_stat_stalls  <= '0;
        end else begin
            if (w_push) begin
                r_stat_results <= r_stat_results + 32'd1;
            end
            if (!cke) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_results = r_stat_results;
    assign stat_stalls  = r_stat_stalls;
`endif

endmodule
